// File: rtl/mig_app_pkg.sv
// Shared types for the DDR app-interface responder:
// command codes, FIFO entry layouts and the execute-engine states.
package mig_app_pkg;

    // Struct field widths; the responder's MEM_AW / AXI_DSIZE defaults follow these.
    localparam int PKG_MEM_AW = 12;
    localparam int PKG_DSIZE  = 256;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef struct packed {
        logic [2:0]            cmd;
        logic [PKG_MEM_AW-1:0] beat;
    } cmd_entry_t;

    typedef struct packed {
        logic [PKG_DSIZE-1:0]   data;
        logic [PKG_DSIZE/8-1:0] mask;
    } wdf_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC_WR,
        EXEC_RD
    } exec_state_t;

    function automatic logic cmd_legal(input logic [2:0] c);
        return (c == CMD_WR) || (c == CMD_RD);
    endfunction

endpackage

// File: rtl/mig_app_responder_fifo.sv
// app_sync_fifo: first-word-fall-through synchronous FIFO.
// Ports: i_clk, i_rst (sync, high), i_push/i_data, i_pop, o_data (head), o_full, o_empty.
module app_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          r_full;
    logic          r_empty;
    logic [AW:0]   w_cnt_nxt;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop & ~r_empty;
    // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
    assign w_push = i_push & (~r_full | w_pop);

    assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_cnt   <= w_cnt_nxt;
            // Flags come from post-pop occupancy and are registered.
            r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/mig_app_responder.sv
// RAM-backed responder for the DDR controller native app interface.
// Ports: app_* command/write/read channels, init_calib_complete, sticky proto_err.
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int ASIZE        = 29,
    parameter int AXI_DSIZE    = PKG_DSIZE,
    parameter int MEM_AW       = PKG_MEM_AW,
    parameter int RD_LATENCY   = 8,
    parameter int CALIB_CYCLES = 64,
    parameter int STALL_PERIOD = 0,
    parameter int FIFO_AW      = 4
) (
    input  logic                   ui_clk,
    input  logic                   ui_clk_sync_rst,
    input  logic [ASIZE-1:0]       app_addr,
    input  logic [2:0]             app_cmd,
    input  logic                   app_en,
    output logic                   app_rdy,
    input  logic [AXI_DSIZE-1:0]   app_wdf_data,
    input  logic [AXI_DSIZE/8-1:0] app_wdf_mask,
    input  logic                   app_wdf_wren,
    input  logic                   app_wdf_end,
    output logic                   app_wdf_rdy,
    output logic [AXI_DSIZE-1:0]   app_rd_data,
    output logic                   app_rd_data_valid,
    output logic                   app_rd_data_end,
    output logic                   init_calib_complete,
    output logic                   proto_err
);

    localparam int NB = AXI_DSIZE / 8;
    localparam int PD = RD_LATENCY;

    logic        r_calib;
    logic [31:0] r_calib_cnt;
    logic        r_proto_err;
    logic        w_stall;

    cmd_entry_t  w_cmd_in;
    cmd_entry_t  w_cmd_head;
    wdf_entry_t  w_wdf_in;
    wdf_entry_t  w_wdf_head;
    logic        w_cmd_full;
    logic        w_cmd_empty;
    logic        w_wdf_full;
    logic        w_wdf_empty;
    logic        w_cmd_acc;
    logic        w_cmd_push;
    logic        w_wdf_push;
    logic        w_cmd_pop;
    logic        w_wdf_pop;
    logic        w_ram_we;
    logic        w_ram_re;
    logic        w_err;

    exec_state_t r_state;
    exec_state_t w_state;
    exec_state_t w_state_nxt;

    logic [AXI_DSIZE-1:0] r_mem [1 << MEM_AW];
    logic [AXI_DSIZE-1:0] r_rdq;
    logic [PD-1:0]                w_pv;
    logic [PD-1:0][AXI_DSIZE-1:0] w_pd;

    logic [ASIZE-MEM_AW-4:0] w_unused_addr;
    assign w_unused_addr = app_addr[ASIZE-1:MEM_AW+3];

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_calib     <= 1'b0;
            r_calib_cnt <= '0;
        end else if (!r_calib) begin
            r_calib_cnt <= r_calib_cnt + 32'd1;
            if (r_calib_cnt == 32'(CALIB_CYCLES - 1)) r_calib <= 1'b1;
        end
    end

    if (STALL_PERIOD > 0) begin : g_stall
        logic [31:0] r_stall_cnt;
        always_ff @(posedge ui_clk) begin
            if (ui_clk_sync_rst)
                r_stall_cnt <= '0;
            else if (r_stall_cnt == 32'(STALL_PERIOD - 1))
                r_stall_cnt <= '0;
            else
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
        assign w_stall = (r_stall_cnt == '0);
    end else begin : g_nostall
        assign w_stall = 1'b0;
    end

    // Built only from registers: no combinational path from app_en.
    assign app_rdy     = r_calib & ~w_cmd_full & ~w_stall;
    assign app_wdf_rdy = r_calib & ~w_wdf_full;

    assign w_cmd_acc  = app_en & app_rdy;
    // Illegal commands complete the handshake but never enter the FIFO.
    assign w_cmd_push = w_cmd_acc & cmd_legal(app_cmd);
    assign w_wdf_push = app_wdf_wren & app_wdf_rdy;

    always_comb begin
        w_cmd_in      = '0;
        w_cmd_in.cmd  = app_cmd;
        w_cmd_in.beat = app_addr[MEM_AW+2:3];
        w_wdf_in      = '0;
        w_wdf_in.data = app_wdf_data;
        w_wdf_in.mask = app_wdf_mask;
    end

    assign w_err = (w_cmd_acc & (~cmd_legal(app_cmd) | (|app_addr[2:0])))
                 | (app_wdf_wren ^ app_wdf_end);

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) r_proto_err <= 1'b0;
        else                 r_proto_err <= r_proto_err | w_err;
    end

    app_sync_fifo #(.W($bits(cmd_entry_t)), .AW(FIFO_AW)) u_cmd_fifo (
        .i_clk   (ui_clk),
        .i_rst   (ui_clk_sync_rst),
        .i_push  (w_cmd_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_cmd_pop),
        .o_data  (w_cmd_head),
        .o_full  (w_cmd_full),
        .o_empty (w_cmd_empty)
    );

    app_sync_fifo #(.W($bits(wdf_entry_t)), .AW(FIFO_AW)) u_wdf_fifo (
        .i_clk   (ui_clk),
        .i_rst   (ui_clk_sync_rst),
        .i_push  (w_wdf_push),
        .i_data  (w_wdf_in),
        .i_pop   (w_wdf_pop),
        .o_data  (w_wdf_head),
        .o_full  (w_wdf_full),
        .o_empty (w_wdf_empty)
    );

    // r_state holds the operation executed last cycle; for reads it is the
    // first valid stage of the read pipe.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) r_state <= IDLE;
        else                 r_state <= w_state_nxt;
    end

    // w_state classifies the FIFO head; w_state_nxt is what executes now.
    always_comb begin
        w_state = IDLE;
        if (!ui_clk_sync_rst && !w_cmd_empty)
            w_state = (w_cmd_head.cmd == CMD_RD) ? EXEC_RD : EXEC_WR;
        w_state_nxt = w_state;
        if (w_state == EXEC_WR && w_wdf_empty) w_state_nxt = IDLE;
    end

    always_comb begin
        w_cmd_pop = 1'b0;
        w_wdf_pop = 1'b0;
        w_ram_we  = 1'b0;
        w_ram_re  = 1'b0;
        unique case (w_state_nxt)
            EXEC_WR: begin
                w_cmd_pop = 1'b1;
                w_wdf_pop = 1'b1;
                w_ram_we  = 1'b1;
            end
            EXEC_RD: begin
                w_cmd_pop = 1'b1;
                w_ram_re  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (w_ram_we) begin
            for (int b = 0; b < NB; b++) begin
                if (!w_wdf_head.mask[b])
                    r_mem[w_cmd_head.beat][8*b +: 8] <= w_wdf_head.data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst)  r_rdq <= '0;
        else if (w_ram_re)    r_rdq <= r_mem[w_cmd_head.beat];
    end

    assign w_pv[0] = (r_state == EXEC_RD);
    assign w_pd[0] = r_rdq;

    for (genvar g = 1; g < PD; g++) begin : g_pipe
        logic                 r_v;
        logic [AXI_DSIZE-1:0] r_d;
        always_ff @(posedge ui_clk) begin
            if (ui_clk_sync_rst) begin
                r_v <= 1'b0;
                r_d <= '0;
            end else begin
                r_v <= w_pv[g-1];
                r_d <= w_pd[g-1];
            end
        end
        assign w_pv[g] = r_v;
        assign w_pd[g] = r_d;
    end

    assign app_rd_data         = w_pd[PD-1];
    assign app_rd_data_valid   = w_pv[PD-1];
    assign app_rd_data_end     = w_pv[PD-1];
    assign init_calib_complete = r_calib;
    assign proto_err           = r_proto_err;

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed self-checking bench for mig_app_responder
// (calibration, read/write, masks, FIFO backpressure, stalls, errors).
module tb_mig_app_responder;

    localparam logic [2:0] WR = 3'b000;
    localparam logic [2:0] RD = 3'b001;

    logic         clk = 1'b0;
    logic         rst;
    logic [28:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [255:0] app_wdf_data;
    logic [31:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [255:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;
    logic         proto_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [255:0] q_data[$];
    logic         q_end[$];
    int           q_cyc[$];

    mig_app_responder #(
        .ASIZE(29), .AXI_DSIZE(256), .MEM_AW(12), .RD_LATENCY(8),
        .CALIB_CYCLES(64), .STALL_PERIOD(5), .FIFO_AW(4)
    ) dut (
        .ui_clk              (clk),
        .ui_clk_sync_rst     (rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .init_calib_complete (init_calib_complete),
        .proto_err           (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (app_rd_data_valid) begin
            q_data.push_back(app_rd_data);
            q_end.push_back(app_rd_data_end);
            q_cyc.push_back(cyc);
        end
    end

    function automatic logic [255:0] lag_data(input int i);
        logic [31:0] w;
        w = 32'hA500_0000 | 32'(i);
        return {8{w}};
    endfunction

    function automatic logic [28:0] lag_addr(input int i);
        return 29'h1000 + 29'(i * 8);
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_end.delete();
        q_cyc.delete();
    endtask

    // Returns acc = cycle count seen at the negedge of the execute cycle.
    task automatic send_cmd(input logic [2:0] c, input logic [28:0] a, output int acc);
        app_en = 1'b1;
        app_cmd = c;
        app_addr = a;
        for (int g = 0; g < 200 && !app_rdy; g++) @(negedge clk);
        acc = cyc + 1;
        if (!app_rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmd_accept_timeout: app_rdy=%b required 1", app_rdy);
        end
        @(negedge clk);
        app_en = 1'b0;
    endtask

    task automatic send_wdf(input logic [255:0] d, input logic [31:0] m);
        app_wdf_wren = 1'b1;
        app_wdf_end = 1'b1;
        app_wdf_data = d;
        app_wdf_mask = m;
        for (int g = 0; g < 200 && !app_wdf_rdy; g++) @(negedge clk);
        if (!app_wdf_rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL wdf_accept_timeout: app_wdf_rdy=%b required 1", app_wdf_rdy);
        end
        @(negedge clk);
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
    endtask

    task automatic wait_rd(input int n);
        for (int k = 0; k < 100 && q_data.size() < n; k++) @(negedge clk);
        if (q_data.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL rd_timeout: beats=%0d required %0d", q_data.size(), n);
        end
    endtask

    task automatic wait_calib();
        for (int k = 0; k < 200 && !init_calib_complete; k++) @(negedge clk);
        n_cmp++;
        if (init_calib_complete !== 1'b1) begin
            n_err++;
            $display("FAIL recalib: calib=%b required 1", init_calib_complete);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end,
             init_calib_complete, proto_err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b required 000000",
                     {app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end,
                      init_calib_complete, proto_err});
        end
        n_cmp++;
        if (app_rd_data !== 256'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h required 0", app_rd_data);
        end
    endtask

    task automatic test_calib();
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k < 64) begin
                if ({init_calib_complete, app_rdy, app_wdf_rdy} !== 3'b000) begin
                    n_err++;
                    $display("FAIL calib_early k=%0d: got %b required 000", k,
                             {init_calib_complete, app_rdy, app_wdf_rdy});
                end
            end else if (init_calib_complete !== 1'b1) begin
                n_err++;
                $display("FAIL calib_rise k=%0d: got %b required 1", k, init_calib_complete);
            end
        end
        n_cmp++;
        if (app_wdf_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL wdf_rdy_after_calib: got %b required 1", app_wdf_rdy);
        end
    endtask

    task automatic test_wr_rd();
        int acc;
        send_wdf({32{8'h11}}, 32'h0);
        send_cmd(WR, 29'h40, acc);
        repeat (3) @(negedge clk);
        clear_q();
        send_cmd(RD, 29'h40, acc);
        wait_rd(1);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (q_data.size() != 1) begin
            n_err++;
            $display("FAIL wr_rd_beats: got %0d required 1", q_data.size());
        end
        if (q_data.size() >= 1) begin
            n_cmp++;
            if (q_data[0] !== {32{8'h11}}) begin
                n_err++;
                $display("FAIL wr_rd_data: got %h required %h", q_data[0], {32{8'h11}});
            end
            n_cmp++;
            if (q_cyc[0] != acc + 8) begin
                n_err++;
                $display("FAIL wr_rd_latency: got %0d required %0d", q_cyc[0] - acc, 8);
            end
            n_cmp++;
            if (q_end[0] !== 1'b1) begin
                n_err++;
                $display("FAIL wr_rd_end: got %b required 1", q_end[0]);
            end
        end
    endtask

    task automatic test_mask();
        int acc;
        logic [255:0] exp;
        exp = {{31{8'hFF}}, 8'h00};
        send_wdf({32{8'hFF}}, 32'h0);
        send_cmd(WR, 29'h80, acc);
        send_wdf(256'h0, 32'hFFFF_FFFE);
        send_cmd(WR, 29'h80, acc);
        repeat (3) @(negedge clk);
        clear_q();
        send_cmd(RD, 29'h80, acc);
        wait_rd(1);
        if (q_data.size() >= 1) begin
            n_cmp++;
            if (q_data[0] !== exp) begin
                n_err++;
                $display("FAIL mask_data: got %h required %h", q_data[0], exp);
            end
        end
    endtask

    task automatic test_data_lag();
        int acc;
        for (int i = 0; i < 16; i++) send_cmd(WR, lag_addr(i), acc);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (app_rdy !== 1'b0) begin
                n_err++;
                $display("FAIL lag_full k=%0d: app_rdy=%b required 0", k, app_rdy);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 16; i++) send_wdf(lag_data(i), 32'h0);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (app_wdf_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL lag_wdf_drain: app_wdf_rdy=%b required 1", app_wdf_rdy);
        end
        clear_q();
        for (int i = 0; i < 16; i++) send_cmd(RD, lag_addr(i), acc);
        wait_rd(16);
        for (int i = 0; i < 16 && i < q_data.size(); i++) begin
            n_cmp++;
            if (q_data[i] !== lag_data(i)) begin
                n_err++;
                $display("FAIL lag_rd[%0d]: got %h required %h", i, q_data[i], lag_data(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int i = 0;
        int lows[$];
        clear_q();
        app_en = 1'b1;
        app_cmd = RD;
        for (int g = 0; g < 200 && i < 20; g++) begin
            app_addr = lag_addr(i % 16);
            if (app_rdy) i++;
            else lows.push_back(cyc);
            @(negedge clk);
        end
        app_en = 1'b0;
        n_cmp++;
        if (i != 20) begin
            n_err++;
            $display("FAIL b2b_issued: got %0d required 20", i);
        end
        n_cmp++;
        if (lows.size() < 4) begin
            n_err++;
            $display("FAIL b2b_stall_count: got %0d required >=4", lows.size());
        end
        for (int k = 1; k < lows.size(); k++) begin
            n_cmp++;
            if (lows[k] - lows[k-1] != 5) begin
                n_err++;
                $display("FAIL b2b_stall_gap[%0d]: got %0d required 5", k, lows[k] - lows[k-1]);
            end
        end
        wait_rd(20);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (q_data.size() != 20) begin
            n_err++;
            $display("FAIL b2b_beats: got %0d required 20", q_data.size());
        end
        for (int k = 0; k < 20 && k < q_data.size(); k++) begin
            n_cmp++;
            if (q_data[k] !== lag_data(k % 16)) begin
                n_err++;
                $display("FAIL b2b_rd[%0d]: got %h required %h", k, q_data[k], lag_data(k % 16));
            end
        end
    endtask

    task automatic test_errors();
        int acc;
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clean: got %b required 0", proto_err);
        end
        clear_q();
        send_cmd(3'b010, 29'h48, acc);
        @(negedge clk);
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_illegal_cmd: got %b required 1", proto_err);
        end
        send_wdf({32{8'h22}}, 32'h0);
        send_cmd(WR, 29'h40, acc);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q_data.size() != 0) begin
            n_err++;
            $display("FAIL err_dropped: beats=%0d required 0", q_data.size());
        end
        send_cmd(RD, 29'h8040, acc);
        wait_rd(1);
        if (q_data.size() >= 1) begin
            n_cmp++;
            if (q_data[0] !== {32{8'h22}}) begin
                n_err++;
                $display("FAIL wrap_data: got %h required %h", q_data[0], {32{8'h22}});
            end
            n_cmp++;
            if (q_cyc[0] != acc + 8) begin
                n_err++;
                $display("FAIL wrap_latency: got %0d required 8", q_cyc[0] - acc);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int acc;
        clear_q();
        send_cmd(RD, 29'h40, acc);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (q_data.size() != 0) begin
            n_err++;
            $display("FAIL rst_mid_read: beats=%0d required 0", q_data.size());
        end
        n_cmp++;
        if ({proto_err, init_calib_complete} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_flags: got %b required 00", {proto_err, init_calib_complete});
        end
        wait_calib();
        clear_q();
        send_cmd(RD, 29'h43, acc);
        @(negedge clk);
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_misaligned: got %b required 1", proto_err);
        end
        wait_rd(1);
        if (q_data.size() >= 1) begin
            n_cmp++;
            if (q_data[0] !== {32{8'h22}}) begin
                n_err++;
                $display("FAIL retained_data: got %h required %h", q_data[0], {32{8'h22}});
            end
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_calib();
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_cleared: got %b required 0", proto_err);
        end
        app_wdf_end = 1'b1;
        @(negedge clk);
        app_wdf_end = 1'b0;
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_wdf_end: got %b required 1", proto_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        app_addr = '0;
        app_cmd = '0;
        app_en = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
        test_reset();
        test_calib();
        test_wr_rd();
        test_mask();
        test_data_lag();
        test_back_to_back();
        test_errors();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mig_app_responder.md
Name: mig_app_responder

Overview:
- Synthesizable responder for the DDR controller native app interface (app_addr/app_cmd/app_en/app_wdf_*/app_rd_data*). It is the memory-controller end that the multiport VDMA arbiter drives.
- Backed by on-chip RAM, with programmable read latency, app_rdy backpressure and a calibration delay.
- Replaces the external DDR IP in block-level sims and on boards without DDR, so VDMA channels can be brought up against it.

Parameters:
- ASIZE, 29, app_addr width.
- AXI_DSIZE, 256, data beat width. One command moves one beat.
- MEM_AW, 12, log2 of RAM depth in beats.
- RD_LATENCY, 8, cycles from read-command execution to app_rd_data_valid. Must be ≥2.
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.
- STALL_PERIOD, 0, app_rdy forced low one cycle out of every STALL_PERIOD cycles. 0 disables this.
- FIFO_AW, 4, log2 depth of the command FIFO and the write-data FIFO.

Ports:
- ui_clk  in  1  sole clock.
- ui_clk_sync_rst  in  1  synchronous, active-high reset.
- app_addr  in  ASIZE  column address. Beat index = app_addr[MEM_AW+2:3].
- app_cmd  in  3  3'b000 write, 3'b001 read. Other codes are a protocol error.
- app_en  in  1  command valid.
- app_rdy  out  1  command accept.
- app_wdf_data  in  AXI_DSIZE  write data.
- app_wdf_mask  in  AXI_DSIZE/8  1 = byte NOT written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat. Must equal app_wdf_wren.
- app_wdf_rdy  out  1  write data accept.
- app_rd_data  out  AXI_DSIZE  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  asserted with every valid beat.
- init_calib_complete  out  1  calibration done.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: app_rdy=0, app_wdf_rdy=0, app_rd_data_valid=0, app_rd_data_end=0, app_rd_data=0, init_calib_complete=0, proto_err=0.
- Reset effects: both FIFOs and the read pipeline are flushed. RAM contents are retained.
- Reset asserted mid-operation drops all in-flight reads without emitting data.
- Calibration: a counter runs from reset release. init_calib_complete rises on cycle CALIB_CYCLES and stays high until the next reset. Before that, app_rdy and app_wdf_rdy are 0.
- Command accept:
  - app_rdy = calib & !cmd_full & !stall_slot. app_rdy is registered from the next-state full flag, so there is no combinational path from app_en.
  - A command is accepted when app_en & app_rdy. {cmd, beat index} is pushed into the command FIFO.
  - app_en while app_rdy=0: the command is not taken, and the initiator must hold it.
- Write data:
  - Accepted when app_wdf_wren & app_wdf_rdy, and pushed as {data, mask} into the wdf FIFO.
  - app_wdf_rdy = calib & !wdf_full. Data may arrive any number of beats before or after its command.
- Execute engine: pops at most one command per cycle, strictly in order. Head states:
  - IDLE: the FIFO is empty.
  - EXEC_WR: a write at the head executes only when the wdf FIFO is non-empty. It pops both FIFOs and writes the RAM per byte, skipping bytes with mask=1. Otherwise it waits with no pop.
  - EXEC_RD: a read at the head always executes. It reads RAM and enters the RD_LATENCY-deep valid/data pipe.
- Read-after-write: a write executed in cycle N is visible to a read executed in cycle N+1 or later. A write and a read never execute in the same cycle.
- Read output: app_rd_data_valid and app_rd_data_end pulse together, exactly RD_LATENCY cycles after the execute cycle, one beat per read, in command order. There is no backpressure on read data.
- Address: upper address bits above MEM_AW+2 are ignored, so the address wraps. app_addr[2:0] ≠ 0 sets proto_err and the command is still executed with the low bits dropped.
- proto_err sets on any of:
  - illegal app_cmd accepted. That command is dropped and not executed.
  - app_wdf_wren ≠ app_wdf_end.
  - app_addr[2:0] ≠ 0.
  - proto_err clears only on reset.
- Stall: a free-running counter modulo STALL_PERIOD. stall_slot is high when the count is 0.
- Simultaneous push and pop on a full FIFO is legal. Full is computed on post-pop occupancy.

Decomposition:
- Package mig_app_pkg holds:
  - CMD_WR=3'b000 and CMD_RD=3'b001.
  - typedef cmd_entry_t {cmd, beat index}.
  - typedef wdf_entry_t {data, mask}.
  - exec state enum {IDLE, EXEC_WR, EXEC_RD}.
- Sub-module app_sync_fifo (parameterized width/depth, first-word-fall-through, full/empty flags) is instantiated twice.
- RAM and the read pipe are inline.

Test Plan:
- Calibration: release reset -> init_calib_complete rises exactly 64 cycles later. app_rdy and app_wdf_rdy stay 0 before that.
- Write/read: write addr 0x40 with data 0x11..11 and mask 0, then read 0x40 -> data 0x11..11 returned exactly 8 cycles after execute, with valid=end=1 for one cycle.
- Byte mask: write 0xFF..FF to 0x80, then write 0x00..00 with mask=0xFFFF_FFFE -> read returns byte0=0x00 and all other bytes 0xFF.
- Data lags command: 16 write commands with no data -> app_rdy drops when the FIFO is full. Then feed data -> all 16 writes commit in order, and readback matches.
- Back-to-back reads: 20 consecutive reads with STALL_PERIOD=5 -> app_rdy low every 5th cycle, and 20 beats return in order with none lost.
- Errors and wrap: app_cmd=3'b010 -> proto_err=1 and the command is dropped. Read at 0x8040 with MEM_AW=12 -> data from beat 8 (wrap). Reset mid-read -> no valid after reset.
